compare_seq_ctrl: RTL and testbench



---
 rtl/cmp_pkg.sv | 28 ++
 rtl/cmp4_slice.sv | 12 +
 rtl/compare_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_compare_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial nibble comparator: FSM state encoding,
// one-hot result constants and the cascade-resolution helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot result encoding {gt,lt,eq}
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // When every nibble matches, the cascade input decides. Only a clean
    // GT or LT code passes through; anything else (EQ, zero, multi-hot)
    // collapses to EQ so the output is always one-hot.
    function automatic logic [2:0] resolve_cascade(input logic [2:0] cas);
        case (cas)
            RES_GT:  return RES_GT;
            RES_LT:  return RES_LT;
            default: return RES_EQ;
        endcase
    endfunction

endpackage

// File: rtl/cmp4_slice.sv
// Combinational 4-bit unsigned magnitude compare slice.
module cmp4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/compare_seq_ctrl.sv
// Serial wide-operand comparator: one 4-bit slice walks the captured
// operands from the most significant nibble down and produces a one-hot
// {gt,lt,eq} result with a single-cycle done pulse.
// Optional macro CMP_EARLY_EXIT_EN: leave RUN on the first differing nibble
// (variable latency). Without it, RUN always lasts NIBBLES cycles.
module compare_seq_ctrl
    import cmp_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    input  logic [2:0]           cas_in,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           f_out
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             decided_reg, decided_next;
    logic [2:0]       f_reg, f_next;
    logic [W-1:0]     a_reg, a_next;
    logic [W-1:0]     b_reg, b_next;
    logic [2:0]       cas_reg, cas_next;

    logic [3:0]       a_nibs [NIBBLES];
    logic [3:0]       b_nibs [NIBBLES];
    logic             slice_gt;
    logic             slice_lt;

    // Split captured operands into nibble arrays so the slice input is a
    // simple index mux on idx.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[4*gi +: 4];
            assign b_nibs[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    cmp4_slice u_slice (
        .a  (a_nibs[idx_reg]),
        .b  (b_nibs[idx_reg]),
        .gt (slice_gt),
        .lt (slice_lt)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            decided_reg <= 1'b0;
            f_reg       <= RES_NONE;
            a_reg       <= '0;
            b_reg       <= '0;
            cas_reg     <= 3'b000;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            decided_reg <= decided_next;
            f_reg       <= f_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            cas_reg     <= cas_next;
        end
    end

    // Next-state logic: capture on start, scan nibbles MSB->LSB, pulse done.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        decided_next = decided_reg;
        f_next       = f_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        cas_next     = cas_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next       = a_in;
                    b_next       = b_in;
                    cas_next     = cas_in;
                    idx_next     = IDX_W'(NIBBLES - 1);
                    decided_next = 1'b0;
                    f_next       = RES_NONE;
                    state_next   = RUN;
                end
            end

            RUN: begin
                // The first differing nibble wins; once decided, the
                // remaining nibbles are still clocked through but ignored.
                if (!decided_reg) begin
                    if (slice_gt) begin
                        f_next       = RES_GT;
                        decided_next = 1'b1;
                    end else if (slice_lt) begin
                        f_next       = RES_LT;
                        decided_next = 1'b1;
                    end else if (idx_reg == '0) begin
                        f_next = resolve_cascade(cas_reg);
                    end
                end

                if (idx_reg == '0) begin
                    state_next = DONE;
                end
`ifdef CMP_EARLY_EXIT_EN
                else if (!decided_reg && (slice_gt || slice_lt)) begin
                    state_next = DONE;
                end
`endif
                else begin
                    idx_next = idx_reg - IDX_W'(1);
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign f_out = f_reg;

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Scoreboard bench for compare_seq_ctrl: the driver pushes the expected
// result and done cycle per accepted start; a monitor pops on each done.
module tb_compare_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         start   = 1'b0;
    logic [W-1:0] a_in    = '0;
    logic [W-1:0] b_in    = '0;
    logic [2:0]   cas_in  = 3'b000;
    logic         busy;
    logic         done;
    logic [2:0]   f_out;

    compare_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cas_in  (cas_in),
        .busy    (busy),
        .done    (done),
        .f_out   (f_out)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] f;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   free_cyc = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference result: unsigned magnitude, ties settled by the cascade code.
    function automatic logic [2:0] model_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] cas);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        if (cas == 3'b100) return 3'b100;
        if (cas == 3'b010) return 3'b010;
        return 3'b001;
    endfunction

    // Number of nibbles the sequencer examines for this operand pair.
    function automatic int model_k(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
        for (int i = NIBBLES - 1; i >= 0; i--) begin
            if (((a >> (4 * i)) & 16'hF) != ((b >> (4 * i)) & 16'hF))
                return NIBBLES - i;
        end
`endif
        return NIBBLES;
    endfunction

    // Called at a negedge during cycle cyc with start about to be high;
    // records the request if the model says the sequencer is idle.
    task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [2:0] cas);
        exp_t e;
        int   k;
        if (cyc >= free_cyc) begin
            k        = model_k(a, b);
            e.f      = model_f(a, b, cas);
            e.cyc    = cyc + 1 + k;
            free_cyc = cyc + k + 2;
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] cas);
        while (cyc < free_cyc) @(negedge sys_clk);
        a_in   = a;
        b_in   = b;
        cas_in = cas;
        start  = 1'b1;
        model_accept(a, b, cas);
        @(negedge sys_clk);
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cas_in = 3'($urandom);
    endtask

    // Random start pulses with junk operands while the sequencer is busy.
    task automatic noise();
        while (cyc < free_cyc) begin
            start  = 1'($urandom);
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            cas_in = 3'($urandom);
            @(negedge sys_clk);
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge sys_clk);
            guard++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && done) begin
                check("busy_with_done", int'(busy), 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    $display("txn done cycle=%0d f_out=%b expected cycle=%0d f=%b",
                             cyc, f_out, e.cyc, e.f);
                    check("result_f", int'(f_out), int'(e.f));
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;
        int           nib;

        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_f", int'(f_out), 0);
        sys_rst  = 1'b0;
        free_cyc = cyc;

        // Directed cases
        issue(16'h8000, 16'h7FFF, 3'b001); noise();
        issue(16'h1234, 16'h1235, 3'b000); noise();
        issue(16'hABCD, 16'hABCD, 3'b100); noise();
        issue(16'hABCD, 16'hABCD, 3'b010); noise();
        issue(16'hABCD, 16'hABCD, 3'b000); noise();
        issue(16'hABCD, 16'hABCD, 3'b111); noise();
        issue(16'h0000, 16'hFFFF, 3'b100); noise();
        drain();

        // Reset asserted mid-RUN: outputs clear at once, no done afterwards
        issue(16'h1234, 16'h1235, 3'b001);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        #1;
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_done", int'(done), 0);
        check("midrun_rst_f", int'(f_out), 0);
        sb.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst  = 1'b0;
        free_cyc = cyc;
        repeat (8) @(negedge sys_clk);
        check("post_rst_f", int'(f_out), 0);

        // start held high for 20 cycles
        a_in   = 16'h0001;
        b_in   = 16'h0000;
        cas_in = 3'b010;
        start  = 1'b1;
        repeat (20) begin
            model_accept(a_in, b_in, cas_in);
            @(negedge sys_clk);
        end
        start = 1'b0;
        drain();

        // Randomised traffic: unrelated, equal, and single-nibble-different pairs
        for (int t = 0; t < 40; t++) begin
            ra  = W'($urandom);
            sel = $urandom_range(0, 2);
            nib = $urandom_range(0, NIBBLES - 1);
            if (sel == 0)
                rb = W'($urandom);
            else if (sel == 1)
                rb = ra;
            else
                rb = ra ^ (W'($urandom_range(1, 15)) << (4 * nib));
            issue(ra, rb, 3'($urandom));
            if ($urandom_range(0, 1) == 1) noise();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
